// File: rtl/div_sequencer.sv
// Multi-cycle radix-2 restoring divider for the EX stage: returns {remainder, quotient}
// as {HI, LO} and holds the pipeline stall until the result is ready.
module div_sequencer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  div_start,
  input  logic                  div_signed,
  input  logic [DATA_W-1:0]     opdata1,
  input  logic [DATA_W-1:0]     opdata2,
  input  logic                  cancel,
  output logic                  stallreq_for_div,
  output logic                  div_ready,
  output logic [2*DATA_W-1:0]   div_result
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BYZERO = 2'd1,
    ON     = 2'd2,
    END    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [DATA_W-1:0]    rem_q, rem_nxt;
  logic [DATA_W-1:0]    quo_q, quo_nxt;
  logic [DATA_W-1:0]    dsor_q, dsor_nxt;
  logic                 quo_neg_q, quo_neg_nxt;
  logic                 rem_neg_q, rem_neg_nxt;
  logic [2*DATA_W-1:0]  result_nxt;

  logic                 sign1, sign2;
  logic [DATA_W-1:0]    op1_abs, op2_abs;
  logic [DATA_W:0]      shifted, diff;
  logic [DATA_W-1:0]    rem_step, quo_step;
  logic [DATA_W-1:0]    rem_fin, quo_fin;

  // Operand magnitudes; the most negative value maps onto itself, which is
  // exactly its unsigned magnitude, so overflow cases wrap naturally.
  always_comb begin
    sign1   = div_signed & opdata1[DATA_W-1];
    sign2   = div_signed & opdata2[DATA_W-1];
    op1_abs = sign1 ? -opdata1 : opdata1;
    op2_abs = sign2 ? -opdata2 : opdata2;
  end

  // One restoring step: dividend bits shift out of quo_q into the partial
  // remainder while quotient bits shift in from the bottom.
  always_comb begin
    shifted = {rem_q, quo_q[DATA_W-1]};
    diff    = shifted - {1'b0, dsor_q};
    if (!diff[DATA_W]) begin
      rem_step = diff[DATA_W-1:0];
      quo_step = {quo_q[DATA_W-2:0], 1'b1};
    end else begin
      rem_step = shifted[DATA_W-1:0];
      quo_step = {quo_q[DATA_W-2:0], 1'b0};
    end
    quo_fin = quo_neg_q ? -quo_step : quo_step;
    rem_fin = rem_neg_q ? -rem_step : rem_step;
  end

  always_comb begin
    state_nxt        = state;
    cnt_nxt          = cnt;
    rem_nxt          = rem_q;
    quo_nxt          = quo_q;
    dsor_nxt         = dsor_q;
    quo_neg_nxt      = quo_neg_q;
    rem_neg_nxt      = rem_neg_q;
    result_nxt       = div_result;
    stallreq_for_div = 1'b0;
    div_ready        = 1'b0;

    unique case (state)
      IDLE: begin
        if (div_start && !cancel) begin
          stallreq_for_div = 1'b1;
          cnt_nxt          = '0;
          rem_nxt          = '0;
          quo_nxt          = op1_abs;
          dsor_nxt         = op2_abs;
          quo_neg_nxt      = sign1 ^ sign2;
          rem_neg_nxt      = sign1;
          state_nxt        = (opdata2 == '0) ? BYZERO : ON;
        end
      end

      BYZERO: begin
        stallreq_for_div = 1'b1;
        if (cancel) begin
          state_nxt = IDLE;
        end else begin
          result_nxt = '0;
          state_nxt  = END;
        end
      end

      ON: begin
        stallreq_for_div = 1'b1;
        if (cancel) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          rem_nxt = rem_step;
          quo_nxt = quo_step;
          if (cnt == LAST_ITER) begin
            cnt_nxt    = '0;
            result_nxt = {rem_fin, quo_fin};
            state_nxt  = END;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end

      END: begin
        div_ready = 1'b1;
        if (!div_start || cancel) begin
          result_nxt = '0;
          state_nxt  = IDLE;
        end
      end

      default: begin
        result_nxt = '0;
        state_nxt  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dsor_q     <= '0;
      quo_neg_q  <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_result <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      rem_q      <= rem_nxt;
      quo_q      <= quo_nxt;
      dsor_q     <= dsor_nxt;
      quo_neg_q  <= quo_neg_nxt;
      rem_neg_q  <= rem_neg_nxt;
      div_result <= result_nxt;
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed self-checking bench for div_sequencer: latency, signed fix-up,
// divide-by-zero, cancel, operand isolation, result hold and async reset.
module tb_div_sequencer;

  logic        clk;
  logic        rst_n;
  logic        div_start;
  logic        div_signed;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        cancel;
  logic        stallreq_for_div;
  logic        div_ready;
  logic [63:0] div_result;

  int n_assert = 0;
  int n_fail   = 0;

  div_sequencer #(.DATA_W(32), .CNT_W(6)) dut (
    .clk              (clk),
    .rst              (rst_n),
    .div_start        (div_start),
    .div_signed       (div_signed),
    .opdata1          (opdata1),
    .opdata2          (opdata2),
    .cancel           (cancel),
    .stallreq_for_div (stallreq_for_div),
    .div_ready        (div_ready),
    .div_result       (div_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full request: stall for 33 cycles, ready at T+33, then drop start and
  // confirm the result clears on the way back to IDLE.
  task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    div_start  = 1'b1;
    div_signed = sgn;
    opdata1    = a;
    opdata2    = b;
    #1;
    chk({tag, "_stall_T"}, 64'(stallreq_for_div), 64'd1);
    for (int k = 1; k <= 32; k++) begin
      tick();
      chk({tag, "_stall_on"}, 64'(stallreq_for_div), 64'd1);
      chk({tag, "_ready_on"}, 64'(div_ready), 64'd0);
    end
    tick();
    chk({tag, "_ready"}, 64'(div_ready), 64'd1);
    chk({tag, "_stall_end"}, 64'(stallreq_for_div), 64'd0);
    chk({tag, "_result"}, div_result, exp);
    div_start = 1'b0;
    tick();
    chk({tag, "_ready_clr"}, 64'(div_ready), 64'd0);
    chk({tag, "_result_clr"}, div_result, 64'd0);
  endtask

  initial begin
    logic seen_ready;

    rst_n      = 1'b0;
    div_start  = 1'b0;
    div_signed = 1'b0;
    opdata1    = '0;
    opdata2    = '0;
    cancel     = 1'b0;
    #12;
    chk("rst_stall", 64'(stallreq_for_div), 64'd0);
    chk("rst_ready", 64'(div_ready), 64'd0);
    chk("rst_result", div_result, 64'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_stall", 64'(stallreq_for_div), 64'd0);

    // 100 / 7 = 14 r 2
    do_div("divu_100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);
    // -7 / 2 = -3 r -1
    do_div("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'h2, 64'hFFFFFFFF_FFFFFFFD);
    // 7 / -2 = -3 r 1
    do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD);
    // signed overflow wraps
    do_div("div_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);

    // Divide by zero: BYZERO at T+1, END at T+2
    div_start  = 1'b1;
    div_signed = 1'b0;
    opdata1    = 32'h1234;
    opdata2    = 32'h0;
    #1;
    chk("dz_stall_T", 64'(stallreq_for_div), 64'd1);
    tick();
    chk("dz_stall_T1", 64'(stallreq_for_div), 64'd1);
    chk("dz_ready_T1", 64'(div_ready), 64'd0);
    tick();
    chk("dz_ready_T2", 64'(div_ready), 64'd1);
    chk("dz_stall_T2", 64'(stallreq_for_div), 64'd0);
    chk("dz_result", div_result, 64'd0);
    div_start = 1'b0;
    tick();
    chk("dz_ready_clr", 64'(div_ready), 64'd0);

    // Cancel in the 10th ON cycle, with start still high (cancel must win in IDLE)
    div_start  = 1'b1;
    div_signed = 1'b0;
    opdata1    = 32'd1000;
    opdata2    = 32'd3;
    for (int k = 1; k <= 10; k++) tick();
    chk("cx_stall_on10", 64'(stallreq_for_div), 64'd1);
    cancel = 1'b1;
    tick();
    chk("cx_stall_idle", 64'(stallreq_for_div), 64'd0);
    chk("cx_ready_idle", 64'(div_ready), 64'd0);
    tick();
    chk("cx_stall_hold", 64'(stallreq_for_div), 64'd0);
    cancel    = 1'b0;
    div_start = 1'b0;
    seen_ready = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (div_ready) seen_ready = 1'b1;
    end
    chk("cx_no_ready", 64'(seen_ready), 64'd0);
    do_div("divu_9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003);

    // Operand isolation: 1000 / 7 = 142 r 6, inputs disturbed mid-divide
    div_start  = 1'b1;
    div_signed = 1'b0;
    opdata1    = 32'd1000;
    opdata2    = 32'd7;
    for (int k = 1; k <= 5; k++) tick();
    opdata1    = 32'hDEADBEEF;
    opdata2    = 32'd1;
    div_signed = 1'b1;
    for (int k = 6; k <= 33; k++) tick();
    chk("iso_ready", 64'(div_ready), 64'd1);
    chk("iso_result", div_result, 64'h00000006_0000008E);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("hold_ready", 64'(div_ready), 64'd1);
      chk("hold_result", div_result, 64'h00000006_0000008E);
      chk("hold_stall", 64'(stallreq_for_div), 64'd0);
    end
    div_start = 1'b0;
    tick();
    chk("hold_ready_clr", 64'(div_ready), 64'd0);
    chk("hold_result_clr", div_result, 64'd0);

    // Async reset in ON cycle 20
    div_start  = 1'b1;
    div_signed = 1'b0;
    opdata1    = 32'h0000FFFF;
    opdata2    = 32'd3;
    for (int k = 1; k <= 20; k++) tick();
    chk("rst_on_stall_pre", 64'(stallreq_for_div), 64'd1);
    #1;
    rst_n     = 1'b0;
    div_start = 1'b0;
    #1;
    chk("rst_on_stall", 64'(stallreq_for_div), 64'd0);
    chk("rst_on_ready", 64'(div_ready), 64'd0);
    chk("rst_on_result", div_result, 64'd0);
    tick();
    tick();
    #2;
    rst_n = 1'b1;
    seen_ready = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (div_ready) seen_ready = 1'b1;
    end
    chk("rst_on_no_ready", 64'(seen_ready), 64'd0);
    do_div("divu_max_1", 1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF);

    // Async reset while END holds a result
    div_start  = 1'b1;
    div_signed = 1'b0;
    opdata1    = 32'd100;
    opdata2    = 32'd7;
    for (int k = 1; k <= 33; k++) tick();
    chk("rst_end_ready_pre", 64'(div_ready), 64'd1);
    chk("rst_end_result_pre", div_result, 64'h00000002_0000000E);
    #1;
    rst_n     = 1'b0;
    div_start = 1'b0;
    #1;
    chk("rst_end_ready", 64'(div_ready), 64'd0);
    chk("rst_end_result", div_result, 64'd0);
    tick();
    #2;
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 64'(div_ready), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
